// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_frame_rx_if.sv
// PS/2 pins in, decoded scan codes out; master is the receiver side.
interface ps2_frame_rx_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ps2_clk, ps2_data,
    output code, code_valid, is_break, is_extended, frame_err, busy
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  code, code_valid, is_break, is_extended, frame_err, busy
  );

endinterface

// File: rtl/ps2_frame_rx_sync_edge.sv
// Synchronises the PS/2 clock and data pins and flags synchronised clock falls.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  // Reset to the idle-high line level so release never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign o_data = r_data_sync[SYNC_STAGES-1];
  assign o_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame deserialiser with E0/F0 prefix folding and frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_frame_rx_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic       w_data;
  logic       w_fall;
  ps2_state_t r_state;
  ps2_state_t w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_sr;
  logic       r_parity;
  logic [TW-1:0] r_to_cnt;
  logic       r_ext_pending;
  logic       r_brk_pending;
  logic [7:0] r_code;
  logic       r_code_valid;
  logic       r_is_break;
  logic       r_is_extended;
  logic       r_frame_err;
  logic       r_busy;
  logic       w_timeout;
  logic       w_stop_fall;
  logic       w_good;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ps2_clk  (bus.ps2_clk),
    .i_ps2_data (bus.ps2_data),
    .o_data     (w_data),
    .o_fall     (w_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_stop_fall = 1'b0;
    w_good      = 1'b0;
    unique case (r_state)
      IDLE:   if (w_fall && !w_data) w_state_nxt = DATA;
      DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = PARITY;
      PARITY: if (w_fall) w_state_nxt = STOP;
      STOP: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_stop_fall = 1'b1;
          w_good      = w_data & (^{r_sr, r_parity});
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A falling edge on the terminal-count cycle takes priority over the timeout.
    if (r_state != IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT_CYCLES)) begin
      w_state_nxt = IDLE;
      w_timeout   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_sr          <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      r_ext_pending <= 1'b0;
      r_brk_pending <= 1'b0;
      r_code        <= '0;
      r_code_valid  <= 1'b0;
      r_is_break    <= 1'b0;
      r_is_extended <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= (w_state_nxt != IDLE);

      if (r_state == IDLE || w_fall) r_to_cnt <= '0;
      else                           r_to_cnt <= r_to_cnt + 1'b1;

      if (r_state == IDLE && w_fall && !w_data) r_bit_cnt <= '0;
      if (r_state == DATA && w_fall) begin
        r_sr      <= {w_data, r_sr[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (r_state == PARITY && w_fall) r_parity <= w_data;

      if (w_stop_fall) begin
        if (!w_good) begin
          r_frame_err   <= 1'b1;
          r_ext_pending <= 1'b0;
          r_brk_pending <= 1'b0;
        end else if (r_sr == PS2_EXT) begin
          r_ext_pending <= 1'b1;
        end else if (r_sr == PS2_BRK) begin
          r_brk_pending <= 1'b1;
        end else begin
          r_code        <= r_sr;
          r_is_break    <= r_brk_pending;
          r_is_extended <= r_ext_pending;
          r_code_valid  <= 1'b1;
          r_ext_pending <= 1'b0;
          r_brk_pending <= 1'b0;
        end
      end

      if (w_timeout) begin
        r_frame_err   <= 1'b1;
        r_ext_pending <= 1'b0;
        r_brk_pending <= 1'b0;
      end
    end
  end

  assign bus.code        = r_code;
  assign bus.code_valid  = r_code_valid;
  assign bus.is_break    = r_is_break;
  assign bus.is_extended = r_is_extended;
  assign bus.frame_err   = r_frame_err;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: prefixes, frame errors, timeout and mid-frame reset.
module tb_ps2_frame_rx;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   valid_cnt;
  int   err_cnt;

  ps2_frame_rx_if bus ();

  ps2_frame_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 5 ms");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses are counted on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.code_valid) valid_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.code_valid || bus.frame_err)
        check_eq("valid_err_excl", {31'd0, bus.code_valid & bus.frame_err}, 32'd0);
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                           input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  // Each PS/2 bit: 10 cycles setup, 20 low, 10 high (40-cycle PS/2 period).
  task automatic send_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = f[i];
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bits(mk_frame(d, par_flip, stop), 11);
  endtask

  initial begin
    int v0;
    int e0;
    int seen;
    logic [10:0] f;
    n_checks  = 0;
    n_fail    = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_code", {24'd0, bus.code}, 32'h00);
    check_eq("rst_valid", {31'd0, bus.code_valid}, 32'd0);
    check_eq("rst_break", {31'd0, bus.is_break}, 32'd0);
    check_eq("rst_ext", {31'd0, bus.is_extended}, 32'd0);
    check_eq("rst_err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Plain make code
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t1_nvalid", valid_cnt - v0, 1);
    check_eq("t1_nerr", err_cnt - e0, 0);
    check_eq("t1_code", {24'd0, bus.code}, 32'h1C);
    check_eq("t1_break", {31'd0, bus.is_break}, 32'd0);
    check_eq("t1_ext", {31'd0, bus.is_extended}, 32'd0);
    check_eq("t1_busy", {31'd0, bus.busy}, 32'd0);

    // Extended break: E0 F0 75
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    check_eq("t2_prefix_nvalid", valid_cnt - v0, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t2_nvalid", valid_cnt - v0, 1);
    check_eq("t2_nerr", err_cnt - e0, 0);
    check_eq("t2_code", {24'd0, bus.code}, 32'h75);
    check_eq("t2_ext", {31'd0, bus.is_extended}, 32'd1);
    check_eq("t2_break", {31'd0, bus.is_break}, 32'd1);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t2b_code", {24'd0, bus.code}, 32'h1C);
    check_eq("t2b_ext", {31'd0, bus.is_extended}, 32'd0);
    check_eq("t2b_break", {31'd0, bus.is_break}, 32'd0);

    // Bad parity and bad stop keep the previous code
    send_frame(8'h75, 1'b0, 1'b1);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t3_par_nerr", err_cnt - e0, 1);
    check_eq("t3_par_nvalid", valid_cnt - v0, 0);
    check_eq("t3_par_code", {24'd0, bus.code}, 32'h75);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("t3_stop_nerr", err_cnt - e0, 1);
    check_eq("t3_stop_nvalid", valid_cnt - v0, 0);
    check_eq("t3_stop_code", {24'd0, bus.code}, 32'h75);
    check_eq("t3_busy", {31'd0, bus.busy}, 32'd0);

    // Error between F0 and the code drops the break prefix
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h33, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t4_nerr", err_cnt - e0, 1);
    check_eq("t4_nvalid", valid_cnt - v0, 1);
    check_eq("t4_code", {24'd0, bus.code}, 32'h1C);
    check_eq("t4_break", {31'd0, bus.is_break}, 32'd0);

    // Timeout: start + 4 data bits, then the PS/2 clock stays high
    v0 = valid_cnt; e0 = err_cnt;
    f = mk_frame(8'h1C, 1'b0, 1'b1);
    send_bits(f, 4);
    @(negedge clk);
    bus.ps2_data = f[4];
    repeat (10) @(negedge clk);
    bus.ps2_clk = 1'b0;
    seen = 0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (i == 20) bus.ps2_clk = 1'b1;
      if (i == 10) check_eq("t5_busy_mid", {31'd0, bus.busy}, 32'd1);
      if (bus.frame_err && seen == 0) seen = i;
    end
    // Low sampled at edge 1, fall after edge 2, counter hits 200 after edge 203.
    check_eq("t5_latency", seen, 204);
    check_eq("t5_nerr", err_cnt - e0, 1);
    check_eq("t5_nvalid", valid_cnt - v0, 0);
    check_eq("t5_busy", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t5_recover_nvalid", valid_cnt - v0, 1);
    check_eq("t5_recover_code", {24'd0, bus.code}, 32'h1C);

    // Reset in mid-frame after an F0 prefix
    send_frame(8'hF0, 1'b0, 1'b1);
    e0 = err_cnt;
    send_bits(mk_frame(8'h75, 1'b0, 1'b1), 6);
    check_eq("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_code", {24'd0, bus.code}, 32'h00);
    check_eq("t6_valid", {31'd0, bus.code_valid}, 32'd0);
    check_eq("t6_break", {31'd0, bus.is_break}, 32'd0);
    check_eq("t6_ext", {31'd0, bus.is_extended}, 32'd0);
    check_eq("t6_err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("t6_busy", {31'd0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("t6_nerr", err_cnt - e0, 0);
    v0 = valid_cnt;
    send_frame(8'h75, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t6_after_nvalid", valid_cnt - v0, 1);
    check_eq("t6_after_code", {24'd0, bus.code}, 32'h75);
    check_eq("t6_after_break", {31'd0, bus.is_break}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Receives raw PS/2 keyboard frames on the system clock and delivers complete scan codes to the keyboard decoder. It synchronises the external PS/2 clock and data lines, detects falling edges of the PS/2 clock, and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). It also folds the E0 (extended) and F0 (break) prefix bytes into flags on the following code. It sits between the PS/2 connector pins and the keyboard decoder, and replaces the ad-hoc capture in the front end.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers (≥2).
- `TIMEOUT_CYCLES`, 100000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `code` output 8: last delivered scan code (prefixes stripped); held between deliveries.
- `code_valid` output 1: one-cycle pulse when `code` and its flags are new.
- `is_break` output 1: delivered code was preceded by F0; valid with `code`.
- `is_extended` output 1: delivered code was preceded by E0; valid with `code`.
- `frame_err` output 1: one-cycle pulse on parity, stop-bit or timeout failure.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- `ps2_clk` and `ps2_data` each pass through an identical `SYNC_STAGES` synchroniser. The falling-edge strobe `fall` is true when the synchronised clock is 0 and its one-cycle-delayed copy is 1. All bit sampling uses the synchronised data in the `fall` cycle.
- The FSM has four states:
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, ignore the edge and stay in IDLE; no error is raised.
  - DATA: on each `fall`, shift the data bit in LSB-first (`sr <= {bit, sr[7:1]}`). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good if the stop bit is 1 and the 8 data bits plus parity contain an odd number of ones. Go to IDLE in both cases.
- Handling a good frame:
  - Byte E0: set `ext_pending`. No output.
  - Byte F0: set `brk_pending`. No output.
  - Any other byte: load `code`, `is_break <= brk_pending`, `is_extended <= ext_pending`, pulse `code_valid`, then clear both pending flags.
- A bad frame pulses `frame_err`, clears both pending flags, and leaves `code`, `is_break` and `is_extended` unchanged.
- Timeout:
  - An idle counter resets on every `fall` and counts only while not in IDLE.
  - When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, clear the pending flags and go to IDLE.
  - If `fall` and terminal count occur in the same cycle, `fall` wins: the bit is taken and the counter resets.
- Reset values: `code`=0x00, `code_valid`=0, `is_break`=0, `is_extended`=0, `frame_err`=0, `busy`=0. Pending flags, shift register and counters are also 0, and state is IDLE.
- Reset asserted mid-frame discards the partial frame and pending prefixes with no `frame_err`.

## Timing
- Synchroniser delay: a `ps2_clk` low first sampled at clk edge k produces `fall` in the cycle after edge k+`SYNC_STAGES`−1.
- All outputs are registered. `code_valid` / `frame_err` are high for exactly the one cycle following the `fall` cycle of the stop bit, i.e. `SYNC_STAGES`+1 clk edges after the first low sample.
- `code_valid` and `frame_err` are never high in the same cycle.
- `busy` rises the cycle after the start-bit `fall` and falls together with the `code_valid`/`frame_err` pulse.
- Throughput is one code per 11 PS/2 clocks. A consumer must accept `code_valid` as a pulse; there is no backpressure.
- PS/2 clock is at most 16.7 kHz, so clk must be ≥ 8× that for edges to be resolved reliably.

## Structure
- `ps2_pkg` holds:
  - the state enum `ps2_state_t` (IDLE, DATA, PARITY, STOP);
  - constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0.
- One sub-module, `ps2_sync_edge`: parameterised synchroniser for clock and data plus the falling-edge detector. It outputs synchronised data and `fall`.
- FSM, timeout counter and prefix logic stay in `ps2_frame_rx`.

## Test plan
Bench uses `TIMEOUT_CYCLES`=200 and a 10 kHz-equivalent PS/2 model.
- Reset, then frame 0x1C with parity 0 and stop 1 → exactly one `code_valid`, `code`=0x1C, `is_break`=0, `is_extended`=0, `busy` low afterwards.
- Sequence E0, F0, 75 (parities 0, 1, 0) → one `code_valid` only, `code`=0x75, `is_extended`=1, `is_break`=1. A following 0x1C frame → both flags 0.
- Frame 0x1C with parity 1 → `frame_err` pulse, no `code_valid`, `code` keeps its previous value. Same for stop bit 0.
- F0 frame, then bad-parity frame, then 0x1C → `is_break`=0 on the 0x1C delivery.
- Start bit plus 4 data bits, then clock held high for 250 cycles → `frame_err` at cycle 200 after the last edge, `busy`=0. The next full frame 0x1C is decoded correctly.
- Assert `reset` after 6 bits of a frame → all outputs 0 immediately, no `frame_err`. The next complete frame decodes normally.
